// File: rtl/sda_axil_pkg.sv
// Shared types and constants for the AXI-Lite to request/response bridge.
package sda_axil_pkg;

    localparam int unsigned TAG_W = 4;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitRsp,
        StBresp,
        StRresp
    } state_e;

endpackage

// File: rtl/sda_axil_hold.sv
// Single-entry valid/data holding register; accepts whenever empty.
module sda_axil_hold #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             ready_o,
    input  logic             clear_i,
    output logic             full_o,
    output logic [Width-1:0] data_o
);

    logic             full_q, full_d;
    logic [Width-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (valid_i && !full_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign ready_o = !full_q;
    assign full_o  = full_q;
    assign data_o  = data_q;

endmodule

// File: rtl/sda_axil_bridge.sv
// AXI-Lite slave that serialises reads/writes into a tagged request/response
// port with a single outstanding transaction and a response timeout.
module sda_axil_bridge
    import sda_axil_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 256,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic             clk_main_a0,
    input  logic             rst_main_n,
    input  logic             sda_cl_awvalid,
    input  logic [31:0]      sda_cl_awaddr,
    output logic             cl_sda_awready,
    input  logic             sda_cl_wvalid,
    input  logic [31:0]      sda_cl_wdata,
    input  logic [3:0]       sda_cl_wstrb,
    output logic             cl_sda_wready,
    output logic             cl_sda_bvalid,
    output logic [1:0]       cl_sda_bresp,
    input  logic             sda_cl_bready,
    input  logic             sda_cl_arvalid,
    input  logic [31:0]      sda_cl_araddr,
    output logic             cl_sda_arready,
    output logic             cl_sda_rvalid,
    output logic [31:0]      cl_sda_rdata,
    output logic [1:0]       cl_sda_rresp,
    input  logic             sda_cl_rready,
    output logic             req_valid,
    output logic             req_write,
    output logic [31:0]      req_addr,
    output logic [31:0]      req_data,
    output logic [3:0]       req_be,
    output logic [TAG_W-1:0] req_tag,
    input  logic             req_ready,
    input  logic             rsp_valid,
    input  logic [31:0]      rsp_data,
    input  logic             rsp_err,
    input  logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_ready
);

    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

    logic        aw_full, w_full, ar_full;
    logic        aw_clr, w_clr, ar_clr;
    logic [31:0] aw_addr, ar_addr, sel_addr;
    logic [35:0] w_bundle;

    sda_axil_hold #(.Width(32)) u_aw_hold (
        .clk_i   (clk_main_a0),
        .rst_ni  (rst_main_n),
        .valid_i (sda_cl_awvalid),
        .data_i  (sda_cl_awaddr),
        .ready_o (cl_sda_awready),
        .clear_i (aw_clr),
        .full_o  (aw_full),
        .data_o  (aw_addr)
    );

    sda_axil_hold #(.Width(36)) u_w_hold (
        .clk_i   (clk_main_a0),
        .rst_ni  (rst_main_n),
        .valid_i (sda_cl_wvalid),
        .data_i  ({sda_cl_wstrb, sda_cl_wdata}),
        .ready_o (cl_sda_wready),
        .clear_i (w_clr),
        .full_o  (w_full),
        .data_o  (w_bundle)
    );

    sda_axil_hold #(.Width(32)) u_ar_hold (
        .clk_i   (clk_main_a0),
        .rst_ni  (rst_main_n),
        .valid_i (sda_cl_arvalid),
        .data_i  (sda_cl_araddr),
        .ready_o (cl_sda_arready),
        .clear_i (ar_clr),
        .full_o  (ar_full),
        .data_o  (ar_addr)
    );

    state_e           state_q, state_d;
    logic             is_wr_q, is_wr_d;
    logic             last_wr_q, last_wr_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [1:0]       resp_q, resp_d;
    logic [31:0]      rdata_q, rdata_d;

    logic wr_el, rd_el;
    assign wr_el = aw_full && w_full;
    assign rd_el = ar_full;

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        last_wr_d = last_wr_q;
        tag_d     = tag_q;
        cur_tag_d = cur_tag_q;
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        aw_clr    = 1'b0;
        w_clr     = 1'b0;
        ar_clr    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // On a tie the type that completed last goes first (read out of reset).
                if (wr_el && (!rd_el || last_wr_q)) begin
                    state_d = StReq;
                    is_wr_d = 1'b1;
                end else if (rd_el) begin
                    state_d = StReq;
                    is_wr_d = 1'b0;
                end
            end
            StReq: begin
                if (req_ready) begin
                    state_d   = StWaitRsp;
                    aw_clr    = is_wr_q;
                    w_clr     = is_wr_q;
                    ar_clr    = !is_wr_q;
                    cnt_d     = '0;
                    cur_tag_d = tag_q;
                    tag_d     = tag_q + 1'b1;
                end
            end
            StWaitRsp: begin
                if (rsp_valid && (rsp_tag == cur_tag_q)) begin
                    state_d = is_wr_q ? StBresp : StRresp;
                    resp_d  = rsp_err ? SLVERR : OKAY;
                    if (!is_wr_q) rdata_d = rsp_data;
                end else if (cnt_q == CntLast) begin
                    state_d = is_wr_q ? StBresp : StRresp;
                    resp_d  = SLVERR;
                    if (!is_wr_q) rdata_d = ERR_RDATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StBresp: begin
                if (sda_cl_bready) begin
                    state_d   = StIdle;
                    last_wr_d = 1'b1;
                end
            end
            StRresp: begin
                if (sda_cl_rready) begin
                    state_d   = StIdle;
                    last_wr_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q   <= StIdle;
            is_wr_q   <= 1'b0;
            last_wr_q <= 1'b0;
            tag_q     <= '0;
            cur_tag_q <= '0;
            cnt_q     <= '0;
            resp_q    <= OKAY;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            last_wr_q <= last_wr_d;
            tag_q     <= tag_d;
            cur_tag_q <= cur_tag_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign sel_addr  = is_wr_q ? aw_addr : ar_addr;
    assign req_valid = (state_q == StReq);
    assign req_write = req_valid && is_wr_q;
    assign req_addr  = req_valid ? {sel_addr[31:2], 2'b00} : 32'd0;
    assign req_data  = req_write ? w_bundle[31:0] : 32'd0;
    assign req_be    = req_write ? w_bundle[35:32] : 4'd0;
    assign req_tag   = tag_q;
    assign rsp_ready = !((state_q == StBresp) || (state_q == StRresp));

    assign cl_sda_bvalid = (state_q == StBresp);
    assign cl_sda_bresp  = cl_sda_bvalid ? resp_q : OKAY;
    assign cl_sda_rvalid = (state_q == StRresp);
    assign cl_sda_rresp  = cl_sda_rvalid ? resp_q : OKAY;
    assign cl_sda_rdata  = rdata_q;

endmodule

// File: tb/tb_sda_axil_bridge.sv
// Directed plus randomized checks of sda_axil_bridge against a transaction-level model.
module tb_sda_axil_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awvalid = 0, wvalid = 0, arvalid = 0, bready = 0, rready = 0;
    logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
    logic [3:0]  wstrb = 0;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_data;
    logic [3:0]  req_be, req_tag;
    logic        req_ready = 0;
    logic        rsp_valid = 0, rsp_err = 0;
    logic [31:0] rsp_data = 0;
    logic [3:0]  rsp_tag = 0;
    logic        rsp_ready;

    sda_axil_bridge #(.TIMEOUT(16), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk_main_a0    (clk),
        .rst_main_n     (rst_n),
        .sda_cl_awvalid (awvalid),
        .sda_cl_awaddr  (awaddr),
        .cl_sda_awready (awready),
        .sda_cl_wvalid  (wvalid),
        .sda_cl_wdata   (wdata),
        .sda_cl_wstrb   (wstrb),
        .cl_sda_wready  (wready),
        .cl_sda_bvalid  (bvalid),
        .cl_sda_bresp   (bresp),
        .sda_cl_bready  (bready),
        .sda_cl_arvalid (arvalid),
        .sda_cl_araddr  (araddr),
        .cl_sda_arready (arready),
        .cl_sda_rvalid  (rvalid),
        .cl_sda_rdata   (rdata),
        .cl_sda_rresp   (rresp),
        .sda_cl_rready  (rready),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_be         (req_be),
        .req_tag        (req_tag),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .rsp_tag        (rsp_tag),
        .rsp_ready      (rsp_ready)
    );

    always #5 clk = ~clk;

    int       n_vec = 0;
    int       n_err = 0;
    bit [3:0] exp_tag = 0;
    bit [3:0] cur_tag = 0;
    bit       last_wr = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s;
        while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
        chk("aw_w_accept", 128'(n < 50), 1);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
    endtask

    task automatic push_read(input logic [31:0] a);
        int n = 0;
        arvalid = 1; araddr = a;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        chk("ar_accept", 128'(n < 50), 1);
        @(negedge clk);
        arvalid = 0;
    endtask

    // Waits for the request, checks its fields, then handshakes after rdly cycles.
    task automatic serve(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input int rdly);
        int n = 0;
        logic [31:0] ea = {a[31:2], 2'b00};
        logic [31:0] ed = wr ? d : 32'd0;
        logic [3:0]  eb = wr ? be : 4'd0;
        while (!req_valid && n < 20) begin @(negedge clk); n++; end
        chk("req_fields", {req_valid, req_write, req_addr, req_data, req_be, req_tag},
            {1'b1, wr, ea, ed, eb, exp_tag});
        repeat (rdly) @(negedge clk);
        chk("req_stable", {req_valid, req_write, req_addr, req_data, req_be, req_tag},
            {1'b1, wr, ea, ed, eb, exp_tag});
        req_ready = 1;
        @(negedge clk);
        req_ready = 0;
        cur_tag = exp_tag;
        exp_tag = exp_tag + 4'd1;
    endtask

    task automatic finish(input bit wr, input int dly, input bit err, input logic [31:0] d,
                          input bit junk, input int hold);
        logic [1:0] er = err ? 2'b10 : 2'b00;
        if (junk) begin
            rsp_valid = 1; rsp_tag = cur_tag ^ 4'h9; rsp_data = ~d; rsp_err = ~err;
            @(negedge clk);
            rsp_valid = 0;
            chk("junk_dropped", {bvalid, rvalid}, 2'b00);
        end
        repeat (dly) @(negedge clk);
        chk("rsp_ready_wait", rsp_ready, 1);
        rsp_valid = 1; rsp_tag = cur_tag; rsp_data = d; rsp_err = err;
        @(negedge clk);
        rsp_valid = 0;
        for (int i = 0; i <= hold; i++) begin
            if (wr) chk("bresp", {bvalid, rvalid, bresp}, {1'b1, 1'b0, er});
            else chk("rresp_rdata", {rvalid, bvalid, rresp, rdata}, {1'b1, 1'b0, er, d});
            if (i < hold) @(negedge clk);
        end
        chk("rsp_ready_busy", rsp_ready, 0);
        if (wr) bready = 1; else rready = 1;
        @(negedge clk);
        bready = 0; rready = 0;
        chk("resp_done", {bvalid, rvalid}, 2'b00);
        last_wr = wr;
    endtask

    task automatic run_pair(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                            input logic [31:0] rd);
        int n = 0;
        awvalid = 1; awaddr = wa; wvalid = 1; wdata = wd; wstrb = 4'hF;
        arvalid = 1; araddr = ra;
        while (!(awready && wready && arready) && n < 50) begin @(negedge clk); n++; end
        chk("pair_accept", 128'(n < 50), 1);
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        if (last_wr) begin
            serve(1, wa, wd, 4'hF, 0); finish(1, 0, 0, 32'd0, 0, 0);
            serve(0, ra, 0, 0, 0);     finish(0, 0, 0, rd, 0, 0);
        end else begin
            serve(0, ra, 0, 0, 0);     finish(0, 0, 0, rd, 0, 0);
            serve(1, wa, wd, 4'hF, 0); finish(1, 0, 0, 32'd0, 0, 0);
        end
    endtask

    initial begin
        int k;
        bit bad;
        repeat (2) @(negedge clk);
        chk("reset_outs", {bvalid, rvalid, req_valid, bresp, rresp, rdata, rsp_ready},
            {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b1});
        chk("reset_req", {req_write, req_addr, req_data, req_be, req_tag}, 0);
        rst_n = 1;
        @(negedge clk);
        chk("ready_after_reset", {awready, wready, arready}, 3'b111);

        // Simultaneous write/read pairs alternate order.
        run_pair(32'h0000_0040, 32'h1111_2222, 32'h0000_0080, 32'hAAAA_5555);
        run_pair(32'h0000_0044, 32'h3333_4444, 32'h0000_0084, 32'h5555_AAAA);

        // Read timeout.
        push_read(32'h0000_0200);
        serve(0, 32'h0000_0200, 0, 0, 0);
        k = 0;
        while (!rvalid && k < 40) begin @(negedge clk); k++; end
        chk("timeout_cycles", k, 16);
        chk("timeout_resp", {rvalid, rresp, rdata}, {1'b1, 2'b10, 32'hDEAD_BEEF});
        rready = 1; @(negedge clk); rready = 0; last_wr = 0;
        rsp_valid = 1; rsp_tag = cur_tag; rsp_data = 32'h0BAD_0BAD; rsp_err = 0;
        chk("late_rsp_taken", rsp_ready, 1);
        @(negedge clk);
        rsp_valid = 0;
        bad = 0;
        repeat (4) begin if (bvalid || rvalid || req_valid) bad = 1; @(negedge clk); end
        chk("late_rsp_dropped", bad, 0);

        // Backpressure on B with a second write queued behind.
        push_write(32'h0000_0300, 32'h0102_0304, 4'h3);
        serve(1, 32'h0000_0300, 32'h0102_0304, 4'h3, 1);
        push_write(32'h0000_0304, 32'h0506_0708, 4'hC);
        chk("queued_full", {awready, wready}, 2'b00);
        finish(1, 1, 1, 32'd0, 0, 10);
        chk("queued_still_full", {awready, wready}, 2'b00);
        serve(1, 32'h0000_0304, 32'h0506_0708, 4'hC, 0);
        chk("queued_dequeued", {awready, wready}, 2'b11);
        finish(1, 0, 0, 32'd0, 0, 0);

        // Randomized single transactions.
        for (int i = 0; i < 12; i++) begin
            bit          wr = 1'($urandom_range(1));
            logic [31:0] a = $urandom;
            logic [31:0] d = $urandom;
            logic [3:0]  s = 4'($urandom);
            logic [31:0] rd = $urandom;
            if (wr) push_write(a, d, s); else push_read(a);
            serve(wr, a, d, s, $urandom_range(3));
            finish(wr, $urandom_range(4), 1'($urandom_range(1)), rd, 1'($urandom_range(1)),
                   $urandom_range(2));
        end

        // Reset while waiting for a response.
        push_read(32'h0000_0400);
        serve(0, 32'h0000_0400, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1;
        chk("midreset_outs", {bvalid, rvalid, req_valid, bresp, rresp, rdata, rsp_ready},
            {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0, 1'b1});
        chk("midreset_ready", {awready, wready, arready, req_tag}, {3'b111, 4'd0});
        @(negedge clk);
        rst_n = 1;
        exp_tag = 0; last_wr = 0;
        bad = 0;
        repeat (24) begin @(negedge clk); if (bvalid || rvalid || req_valid) bad = 1; end
        chk("abandoned_silent", bad, 0);

        // Basic write then read after reset.
        push_write(32'h0000_0010, 32'hCAFE_F00D, 4'hF);
        @(negedge clk);
        chk("req_latency", req_valid, 1);
        serve(1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 0);
        finish(1, 3, 0, 32'd0, 0, 0);
        push_read(32'h0000_0013);
        serve(0, 32'h0000_0013, 0, 0, 0);
        finish(0, 1, 0, 32'h1234_5678, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
